imem_boot_loader: RTL and testbench

- Upstream of the single-cycle RISC-V core. Receives a program as a byte stream over a valid/ready link and assembles it into 32-bit little-endian words.
- Writes each word into the instruction memory write port at consecutive word-aligned byte addresses starting at 0.
- Holds the core in reset until the whole image is written, then releases it.
- Sits between the host link and the Instruction_Memory and Program_Counter reset domain.

---
 rtl/imem_boot_loader.sv | 146 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit words,
// writes them to instruction memory from address 0 and holds the core in reset until done.
module imem_boot_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             reload,
    output logic             imem_we,
    output logic [63:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_run,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded,
    output logic [2:0]       dbg_state
);

    // Handshake: a byte transfers on a rising clk edge where in_valid & in_ready are both 1;
    // in_valid may drop at any time and in_data is only looked at on a transfer.

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state;
    logic [7:0]       count_lo;
    logic [CNT_W-1:0] count;
    logic [1:0]       byte_idx;
    logic [23:0]      asm_q;

    logic        xfer;
    logic [15:0] hdr;
    logic        hdr_bad;
    logic        last_word;

    assign xfer      = in_valid & in_ready;
    assign hdr       = {in_data, count_lo};
    assign hdr_bad   = (hdr == 16'd0) || (int'(hdr) > DEPTH_WORDS);
    assign last_word = (words_loaded + CNT_W'(1)) == count;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_LEN0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_run     <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            count_lo     <= '0;
            count        <= '0;
            byte_idx     <= '0;
            asm_q        <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_LEN0: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        count_lo <= in_data;
                        busy     <= 1'b1;
                        state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        if (hdr_bad) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            count    <= CNT_W'(hdr);
                            byte_idx <= '0;
                            state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        case (byte_idx)
                            2'd0: asm_q[7:0]   <= in_data;
                            2'd1: asm_q[15:8]  <= in_data;
                            2'd2: asm_q[23:16] <= in_data;
                            default: begin
                                // Fourth byte completes the word; the write goes out next cycle.
                                imem_we      <= 1'b1;
                                imem_wdata   <= {in_data, asm_q};
                                imem_addr    <= {{(62-CNT_W){1'b0}}, words_loaded, 2'b00};
                                words_loaded <= words_loaded + CNT_W'(1);
                                if (last_word) begin
                                    state    <= S_DONE;
                                    in_ready <= 1'b0;
                                end
                            end
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_DONE: begin
                    // Entered on the last write's edge, so core_run trails imem_we by one cycle.
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    core_run <= 1'b1;
                    if (reload) begin
                        state        <= S_LEN0;
                        core_run     <= 1'b0;
                        words_loaded <= '0;
                        imem_addr    <= '0;
                        in_ready     <= 1'b1;
                    end
                end
                S_ERR: begin
                    in_ready <= 1'b0;
                    err      <= 1'b1;
                    busy     <= 1'b0;
                    core_run <= 1'b0;
                    if (reload) begin
                        state        <= S_LEN0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        imem_addr    <= '0;
                        in_ready     <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_LEN0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: header table, fixed test-plan sequences and random images
// checked against a word-level model of the expected memory writes.
module tb_imem_boot_loader;

    localparam int DEPTH_WORDS = 64;
    localparam int CNT_W       = 16;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             reload;
    logic             imem_we;
    logic [63:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic             core_run;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] words_loaded;
    logic [2:0]       dbg_state;

    imem_boot_loader #(.DEPTH_WORDS(DEPTH_WORDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_run(core_run), .busy(busy), .err(err),
        .words_loaded(words_loaded), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int writes  = 0;
    logic [63:0] last_addr = '0;
    logic [95:0] exp_q[$];

    typedef struct {
        logic [15:0] hdr;
        bit          exp_err;
        int          gap_max;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every write must match the next expected {addr, data}
    always @(negedge clk) begin
        if (reset && imem_we) begin
            logic [95:0] e;
            writes++;
            last_addr = imem_addr;
            check("core_run_during_write", {63'd0, core_run}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", imem_addr, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", imem_addr, e[95:32]);
                check("write_data", {32'd0, imem_wdata}, {32'd0, e[31:0]});
            end
        end
    end

    // driver tasks: always entered and left on a negedge
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        in_valid = 1'b1;
        in_data  = b;
        for (int g = 0; g < 200; g++) begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) return;
        end
        check("send_byte_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_gap(input int gap_max);
        int gap;
        gap = $urandom_range(0, gap_max);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
    endtask

    // Reference: word i is bytes 4i..4i+3 little-endian, written at byte address 4*i.
    task automatic load_image(input int nwords, input int gap_max, input int reload_at);
        logic [31:0] w;
        logic [7:0]  b;
        send_byte(8'(nwords));
        send_byte(8'(nwords >> 8));
        for (int i = 0; i < nwords; i++) begin
            w = $urandom;
            exp_q.push_back({64'(i * 4), w});
            for (int k = 0; k < 4; k++) begin
                idle_gap(gap_max);
                b = 8'((w >> (8 * k)) % 256);
                reload = (i * 4 + k == reload_at);
                send_byte(b);
                reload = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_run();
        for (int c = 0; c < 50 && !core_run; c++) @(negedge clk);
        check("core_run_released", {63'd0, core_run}, 64'd1);
    endtask

    task automatic check_done(input int nwords);
        check("words_loaded", 64'(words_loaded), 64'(nwords));
        check("in_ready_done", {63'd0, in_ready}, 64'd0);
        check("err_done", {63'd0, err}, 64'd0);
        check("busy_done", {63'd0, busy}, 64'd0);
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_core_run", {63'd0, core_run}, 64'd0);
        check("reload_err", {63'd0, err}, 64'd0);
        check("reload_in_ready", {63'd0, in_ready}, 64'd1);
        check("reload_words", 64'(words_loaded), 64'd0);
        check("reload_addr", imem_addr, 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_we"}, {63'd0, imem_we}, 64'd0);
        check({tag, "_addr"}, imem_addr, 64'd0);
        check({tag, "_wdata"}, {32'd0, imem_wdata}, 64'd0);
        check({tag, "_core_run"}, {63'd0, core_run}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        vec_t vecs[8];
        logic [7:0] img[10];
        int w0;

        reset = 1'b0; in_valid = 1'b0; in_data = '0; reload = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        // Two-word image, back to back, with exact latency checks.
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        exp_q.push_back({64'd0, 32'h00500013});
        exp_q.push_back({64'd4, 32'h00A00093});
        w0 = writes;
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i]);
            if (i == 1) check("busy_in_data", {63'd0, busy}, 64'd1);
        end
        in_valid = 1'b0;
        check("last_we_T1", {63'd0, imem_we}, 64'd1);
        check("core_run_T1", {63'd0, core_run}, 64'd0);
        check("in_ready_T1", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check("core_run_T2", {63'd0, core_run}, 64'd1);
        check("we_T2", {63'd0, imem_we}, 64'd0);
        check("two_writes", 64'(writes - w0), 64'd2);
        check_done(2);
        pulse_reload();

        // Header table: illegal counts go to ERR, legal ones load randomized images.
        vecs[0] = '{16'h0000, 1'b1, 0};
        vecs[1] = '{16'h0041, 1'b1, 0};
        vecs[2] = '{16'hFFFF, 1'b1, 0};
        vecs[3] = '{16'h0040, 1'b0, 0};
        vecs[4] = '{16'h0001, 1'b0, 3};
        vecs[5] = '{16'h0003, 1'b0, 2};
        vecs[6] = '{16'h0100, 1'b1, 0};
        vecs[7] = '{16'h0005, 1'b0, 1};
        for (int v = 0; v < 8; v++) begin
            w0 = writes;
            if (vecs[v].exp_err) begin
                send_byte(vecs[v].hdr[7:0]);
                send_byte(vecs[v].hdr[15:8]);
                in_valid = 1'b1;
                repeat (3) @(negedge clk);
                in_valid = 1'b0;
                check("hdr_err", {63'd0, err}, 64'd1);
                check("hdr_err_core_run", {63'd0, core_run}, 64'd0);
                check("hdr_err_in_ready", {63'd0, in_ready}, 64'd0);
                check("hdr_err_busy", {63'd0, busy}, 64'd0);
                check("hdr_err_no_write", 64'(writes - w0), 64'd0);
            end else begin
                load_image(int'(vecs[v].hdr), vecs[v].gap_max, -1);
                wait_run();
                check_done(int'(vecs[v].hdr));
                check("hdr_write_count", 64'(writes - w0), 64'(vecs[v].hdr));
                if (vecs[v].hdr == 16'h0040) check("final_addr_fc", last_addr, 64'hFC);
            end
            pulse_reload();
        end

        // One word with in_valid toggling every cycle: same write, exactly once.
        w0 = writes;
        exp_q.push_back({64'd0, 32'h00500013});
        img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            send_byte(img[i]);
            in_valid = 1'b0;
            @(negedge clk);
        end
        wait_run();
        check("toggle_single_write", 64'(writes - w0), 64'd1);
        check_done(1);
        pulse_reload();

        // Reset after 6 bytes of a 2-word image; then a fresh load from address 0.
        exp_q.push_back({64'd0, 32'h00500013});
        for (int i = 0; i < 6; i++) send_byte(i < 2 ? (i == 0 ? 8'h02 : 8'h00) : img[i]);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_all_zero("midload_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("in_ready_after_midload_reset", {63'd0, in_ready}, 64'd1);
        load_image(1, 1, -1);
        wait_run();
        check_done(1);
        check("fresh_load_addr0", last_addr, 64'd0);

        // reload in DONE drops core_run; reload mid-DATA is ignored.
        pulse_reload();
        load_image(2, 1, 3);
        wait_run();
        check_done(2);
        pulse_reload();

        // Random images of random size and pacing.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 12);
            w0 = writes;
            load_image(n, $urandom_range(0, 3), -1);
            wait_run();
            check_done(n);
            check("rand_write_count", 64'(writes - w0), 64'(n));
            pulse_reload();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
